encrypter_core: RTL and testbench

- Encrypts a plaintext message held in data memory and writes the ciphertext back to memory, one byte per clock.
- Output stream is a run of 0x7E preamble bytes followed by the plaintext bytes.
- Each byte's low 5 bits are XORed with a 5-bit maximal-length LFSR state; the upper 3 bits pass through.
- Sits beside the decrypter and drives the same data-memory read/write port pair; its output region is the decrypter's input region.

---
 rtl/enc_pkg.sv | 39 +++
 rtl/enc_lfsr.sv | 37 +++
 rtl/encrypter_core.sv | 178 +++++++++++++++++
 tb/tb_encrypter_core.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and constants for the encrypter core: the LFSR tap table,
// the preamble byte, the minimum preamble length and the FSM state type.
package enc_pkg;

  localparam logic [7:0] PREAMBLE = 8'h7E;
  localparam logic [3:0] MIN_PRE  = 4'd6;

  // Index 0 sits in the low slice: TAP_LUT[0] = 5'h1E ... TAP_LUT[5] = 5'h12.
  localparam logic [5:0][4:0] TAP_LUT = {5'h12, 5'h14, 5'h17, 5'h1B, 5'h1D, 5'h1E};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    MSG  = 2'd2,
    DONE = 2'd3
  } enc_state_t;

  // Tap pattern for a selector; out-of-range selectors map to zero and are
  // rejected by the start validation before they are ever used.
  function automatic logic [4:0] tap_of(input logic [2:0] sel);
    logic [4:0] t;
    case (sel)
      3'd0:    t = TAP_LUT[0];
      3'd1:    t = TAP_LUT[1];
      3'd2:    t = TAP_LUT[2];
      3'd3:    t = TAP_LUT[3];
      3'd4:    t = TAP_LUT[4];
      3'd5:    t = TAP_LUT[5];
      default: t = 5'h00;
    endcase
    return t;
  endfunction

  // Requested preamble lengths below the minimum are stretched to it.
  function automatic logic [3:0] eff_pre_of(input logic [3:0] pre_len);
    return (pre_len < MIN_PRE) ? MIN_PRE : pre_len;
  endfunction

endpackage

// File: rtl/enc_lfsr.sv
// 5-bit Fibonacci-style LFSR with synchronous load and advance.
// Shift is left; the new LSB is the parity of state & taps.
module enc_lfsr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] seed,
  input  logic       advance,
  input  logic [4:0] taps,
  output logic [4:0] state
);

  logic [4:0] lfsr_q;
  logic [4:0] lfsr_d;

  // Load has priority so a new run always starts from the seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (advance) begin
      lfsr_d = {lfsr_q[3:0], ^(lfsr_q & taps)};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 5'h00;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/encrypter_core.sv
// Encrypter core: writes a preamble of 0x7E bytes followed by the plaintext
// into the ciphertext region, XORing each byte's low 5 bits with an LFSR.
// Optional build macro ENC_XSUM_EN adds the xsum running-XOR output.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   PRE   | writing encrypted preamble bytes, cnt = 0..eff_pre-1
//   MSG   | copying encrypted plaintext, cnt = eff_pre..OUT_LEN-1
//   DONE  | run finished (err tells whether it was rejected); start re-arms
module encrypter_core
  import enc_pkg::*;
#(
  parameter logic [7:0] MSG_BASE = 8'd0,
  parameter logic [7:0] ENC_BASE = 8'd128,
  parameter int         OUT_LEN  = 64
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       start,
  input  logic [2:0] tap_sel,
  input  logic [4:0] seed,
  input  logic [3:0] pre_len,
  output logic [7:0] mem_raddr,
  input  logic [7:0] mem_rdata,
  output logic       mem_we,
  output logic [7:0] mem_waddr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef ENC_XSUM_EN
  ,
  output logic [7:0] xsum
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(OUT_LEN - 1);

  enc_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] eff_pre_q, eff_pre_d;
  logic [4:0] taps_q, taps_d;
  logic       err_q, err_d;
  logic       lfsr_load;
  logic       lfsr_adv;
  logic [4:0] lfsr;
  logic       cfg_ok;
  logic [7:0] pre_last;

  assign cfg_ok   = (seed != 5'h00) && (tap_sel <= 3'd5);
  assign pre_last = {4'b0, eff_pre_q} - 8'd1;

  enc_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (init_n),
    .load    (lfsr_load),
    .seed    (seed),
    .advance (lfsr_adv),
    .taps    (taps_q),
    .state   (lfsr)
  );

  // Next-state logic; config is captured only on the accepting edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    eff_pre_d = eff_pre_q;
    taps_d    = taps_q;
    err_d     = err_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (cfg_ok) begin
            taps_d    = tap_of(tap_sel);
            eff_pre_d = eff_pre_of(pre_len);
            lfsr_load = 1'b1;
            cnt_d     = 8'd0;
            err_d     = 1'b0;
            state_d   = PRE;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      PRE: begin
        lfsr_adv = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        if (cnt_q == pre_last) begin
          state_d = MSG;
        end
      end
      MSG: begin
        lfsr_adv = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port and status outputs are decoded straight from the state so
  // an async reset returns them to their idle values immediately.
  always_comb begin
    mem_we    = 1'b0;
    mem_raddr = MSG_BASE;
    mem_waddr = ENC_BASE;
    mem_wdata = 8'h00;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      PRE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = ENC_BASE + cnt_q;
        mem_wdata = PREAMBLE ^ {3'b000, lfsr};
      end
      MSG: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_raddr = MSG_BASE + (cnt_q - {4'b0, eff_pre_q});
        mem_waddr = ENC_BASE + cnt_q;
        mem_wdata = {mem_rdata[7:5], mem_rdata[4:0] ^ lfsr};
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

  // Control registers.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      eff_pre_q <= MIN_PRE;
      taps_q    <= 5'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      eff_pre_q <= eff_pre_d;
      taps_q    <= taps_d;
      err_q     <= err_d;
    end
  end

`ifdef ENC_XSUM_EN
  logic [7:0] xsum_q, xsum_d;

  // Running XOR of written bytes, cleared by any start taken in IDLE/DONE.
  always_comb begin
    xsum_d = xsum_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      xsum_d = 8'h00;
    end else if (mem_we) begin
      xsum_d = xsum_q ^ mem_wdata;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      xsum_q <= 8'h00;
    end else begin
      xsum_q <= xsum_d;
    end
  end

  assign xsum = xsum_q;
`endif

endmodule

// File: tb/tb_encrypter_core.sv
// Directed testbench for encrypter_core: models the data memory and checks
// ciphertext, timing, error handling and reset behaviour.
module tb_encrypter_core;

  logic       clk;
  logic       init_n;
  logic       start;
  logic [2:0] tap_sel;
  logic [4:0] seed;
  logic [3:0] pre_len;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic       err;
`ifdef ENC_XSUM_EN
  logic [7:0] xsum;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] pt [128];
  logic [7:0] ct [128];
  logic [7:0] exp_b [64];
  logic [4:0] tb_taps [6];
  logic       ct_clr;
  logic [7:0] last_raddr;

  encrypter_core dut (
    .clk       (clk),
    .init_n    (init_n),
    .start     (start),
    .tap_sel   (tap_sel),
    .seed      (seed),
    .pre_len   (pre_len),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef ENC_XSUM_EN
    ,
    .xsum      (xsum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_raddr[7] ? 8'h00 : pt[mem_raddr[6:0]];

  always @(posedge clk) begin
    if (ct_clr) begin
      for (int i = 0; i < 128; i++) ct[i] <= 8'h00;
    end else if (mem_we && mem_waddr[7]) begin
      ct[mem_waddr[6:0]] <= mem_wdata;
    end
    if (mem_we && mem_waddr == 8'd191) last_raddr <= mem_raddr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Expected ciphertext for the full 64-byte window.
  task automatic build_exp(input logic [4:0] taps, input logic [4:0] sd, input int eff);
    logic [4:0] s;
    logic [7:0] b;
    s = sd;
    for (int i = 0; i < 64; i++) begin
      b = (i < eff) ? 8'h7E : pt[i - eff];
      exp_b[i] = {b[7:5], b[4:0] ^ s};
      s = {s[3:0], ^(s & taps)};
    end
  endtask

  task automatic cmp_exp(input string tag);
    for (int i = 0; i < 64; i++) check(tag, ct[i], exp_b[i]);
  endtask

  // Decrypt the ciphertext window independently and compare to the source.
  task automatic decrypt_check(input logic [4:0] taps, input logic [4:0] sd, input int eff);
    logic [4:0] s;
    logic [7:0] p;
    s = sd;
    for (int i = 0; i < 64; i++) begin
      p = ct[i] ^ {3'b000, s};
      check("roundtrip", p, (i < eff) ? 8'h7E : pt[i - eff]);
      s = {s[3:0], ^(s & taps)};
    end
  endtask

`ifdef ENC_XSUM_EN
  task automatic check_xsum();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 64; i++) x = x ^ ct[i];
    check("xsum", xsum, x);
  endtask
`endif

  // One run: clear output region, pulse start, then scramble the config
  // inputs. Cycle 1 is the first cycle after the accepting edge.
  task automatic run_enc(input logic [2:0] ts, input logic [4:0] sd, input logic [3:0] pl,
                         input int inj, output int done_cyc, output int we_cnt);
    @(negedge clk);
    ct_clr = 1'b1;
    @(negedge clk);
    ct_clr  = 1'b0;
    tap_sel = ts;
    seed    = sd;
    pre_len = pl;
    start   = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    tap_sel  = ~ts;
    seed     = ~sd;
    pre_len  = ~pl;
    done_cyc = 0;
    we_cnt   = 0;
    for (int c = 1; c <= 200; c++) begin
      if (mem_we) we_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (c == inj) begin
        start   = 1'b1;
        seed    = 5'h1F;
        tap_sel = 3'd3;
        pre_len = 4'd15;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_err"},   err, 1'b0);
    check({tag, "_we"},    mem_we, 1'b0);
    check({tag, "_raddr"}, mem_raddr, 8'd0);
    check({tag, "_waddr"}, mem_waddr, 8'd128);
    check({tag, "_wdata"}, mem_wdata, 8'h00);
`ifdef ENC_XSUM_EN
    check({tag, "_xsum"},  xsum, 8'h00);
`endif
  endtask

  initial begin
    int dc, wc, eff;
    logic [4:0] seeds [3];
    tb_taps[0] = 5'h1E; tb_taps[1] = 5'h1D; tb_taps[2] = 5'h1B;
    tb_taps[3] = 5'h17; tb_taps[4] = 5'h14; tb_taps[5] = 5'h12;
    seeds[0] = 5'h01; seeds[1] = 5'h1F; seeds[2] = 5'h0A;
    init_n = 1'b0; start = 1'b0; tap_sel = 3'd0; seed = 5'h00; pre_len = 4'd0;
    ct_clr = 1'b0;
    for (int i = 0; i < 128; i++) pt[i] = 8'h00;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    init_n = 1'b1;

    // Basic vector with hand-computed first bytes.
    for (int i = 0; i < 58; i++) pt[i] = 8'h41;
    run_enc(3'd0, 5'h01, 4'd6, 0, dc, wc);
    check("basic_done_cyc", dc, 65);
    check("basic_we_cnt", wc, 64);
    check("basic_err", err, 1'b0);
    check("basic_b0", ct[0], 8'h7F);
    check("basic_b1", ct[1], 8'h7C);
    check("basic_b2", ct[2], 8'h7B);
    check("basic_b3", ct[3], 8'h75);
    build_exp(5'h1E, 5'h01, 6);
    cmp_exp("basic_byte");
`ifdef ENC_XSUM_EN
    check_xsum();
`endif

    // Round trip over every tap pattern, several seeds and preamble lengths.
    for (int i = 0; i < 128; i++) pt[i] = 8'($urandom);
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 3; k++) begin
        run_enc(3'(t), seeds[k], 4'((t * 3 + k * 5) % 16), 0, dc, wc);
        eff = ((t * 3 + k * 5) % 16 < 6) ? 6 : (t * 3 + k * 5) % 16;
        check("rt_done_cyc", dc, 65);
        check("rt_err", err, 1'b0);
        decrypt_check(tb_taps[t], seeds[k], eff);
      end
    end

    // Rejected configurations.
    run_enc(3'd0, 5'h00, 4'd6, 0, dc, wc);
    check("seed0_done_cyc", dc, 1);
    check("seed0_err", err, 1'b1);
    check("seed0_we_cnt", wc, 0);
    check("seed0_ct0", ct[0], 8'h00);
`ifdef ENC_XSUM_EN
    check("seed0_xsum", xsum, 8'h00);
`endif
    run_enc(3'd6, 5'h05, 4'd6, 0, dc, wc);
    check("tap6_done_cyc", dc, 1);
    check("tap6_err", err, 1'b1);
    check("tap6_we_cnt", wc, 0);
    run_enc(3'd7, 5'h05, 4'd6, 0, dc, wc);
    check("tap7_err", err, 1'b1);
    check("tap7_we_cnt", wc, 0);

    // Short preamble request is stretched to six bytes.
    run_enc(3'd2, 5'h13, 4'd3, 0, dc, wc);
    check("pre3_done_cyc", dc, 65);
    check("pre3_err", err, 1'b0);
    check("pre3_last_raddr", last_raddr, 8'd57);
    build_exp(5'h1B, 5'h13, 6);
    cmp_exp("pre3_byte");

    // Reset during the preamble, then a clean run.
    @(negedge clk);
    tap_sel = 3'd1; seed = 5'h07; pre_len = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_busy_before_rst", busy, 1'b1);
    init_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check("midrst_held_busy", busy, 1'b0);
    init_n = 1'b1;
    run_enc(3'd1, 5'h07, 4'd8, 0, dc, wc);
    check("postrst_done_cyc", dc, 65);
    build_exp(5'h1D, 5'h07, 8);
    cmp_exp("postrst_byte");

    // Start pulsed in the middle of the message section is ignored.
    run_enc(3'd4, 5'h15, 4'd12, 20, dc, wc);
    check("ign_done_cyc", dc, 65);
    check("ign_we_cnt", wc, 64);
    build_exp(5'h14, 5'h15, 12);
    cmp_exp("ign_byte");
`ifdef ENC_XSUM_EN
    check_xsum();
`endif
    repeat (3) @(negedge clk);
    check("done_stable", done, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
